if_id_stage: RTL and testbench
==============================

IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port hazard, input, 1 bit: stall request from the hazard unit, the same signal fed to IDEXBuffer.
REQ-004 SHALL have port branch_taken, input, 1 bit: redirect-and-flush request from EX.
REQ-005 SHALL have port branch_target, input, 16 bits: redirect address.
REQ-006 SHALL have port instr_in, input, 16 bits: instruction memory read data for pc_out, available in the same cycle.
REQ-007 SHALL have port pc_out, output, 16 bits: fetch address to instruction memory.
REQ-008 SHALL have port instr_o, output, 16 bits: registered instruction to ID.
REQ-009 SHALL have port PC_o, output, 16 bits: registered PC+2 of instr_o, consumed by the ID/EX buffer.
REQ-010 SHALL have port valid_o, output, 1 bit: instr_o is a real instruction, not a bubble.
REQ-011 SHALL have port stall_cnt, output, 8 bits: consecutive-stall counter (see Configuration).

Function
REQ-012 SHALL give each rising edge a fixed priority: branch_taken, then hazard, then normal advance.
REQ-013 Normal advance SHALL perform:
- pc_out <= pc_out+2
- instr_o <= instr_in
- PC_o <= pc_out+2
- valid_o <= 1
REQ-014 Stall (hazard=1, branch_taken=0) SHALL hold pc_out, instr_o, PC_o and valid_o unchanged.
REQ-015 Flush (branch_taken=1) SHALL perform the following, regardless of hazard:
- pc_out <= {branch_target[15:1],1'b0}
- instr_o <= 16'h0000 (NOP)
- PC_o <= 0
- valid_o <= 0
REQ-016 pc_out SHALL always be even; the increment SHALL wrap modulo 2^16 (16'hFFFE -> 16'h0000).
REQ-017 PC_o SHALL equal the truncated 16-bit sum; PC_o=16'h0000 SHALL result when fetching from 16'hFFFE.
REQ-018 Fetch-to-ID latency SHALL be exactly one edge: the instruction addressed by pc_out in cycle n appears on instr_o after edge n+1, unless stalled or flushed.
REQ-019 A stall SHALL NOT drop or duplicate any instruction: the first advance after a stall latches instr_in for the held pc_out.
REQ-020 Successive flush cycles SHALL each redirect to the current branch_target and keep valid_o=0.

Reset
REQ-021 When reset=0, the block SHALL immediately, without waiting for clk, force:
- pc_out=16'h0000
- instr_o=16'h0000
- PC_o=16'h0000
- valid_o=0
- stall_cnt=0
REQ-022 Reset asserted mid-stall or mid-flush SHALL override all inputs.
REQ-023 The first edge after reset rises SHALL behave as a normal advance from pc_out=0, unless hazard or branch_taken is high.

Configuration
REQ-024 With macro IFID_STALL_CNT_EN defined, stall_cnt SHALL behave as follows:
- increments by 1 on each edge with hazard=1 and branch_taken=0
- saturates at 8'hFF
- clears to 0 on any edge without a stall
REQ-025 With IFID_STALL_CNT_EN undefined, stall_cnt SHALL be tied to 8'h00, no counter logic SHALL be present, and the port list SHALL be unchanged.

Verification
REQ-026 Reset/advance: hold reset=0 for 2 cycles, then release with instr_in=16'h1234 -> after the first edge pc_out=2, instr_o=16'h1234, PC_o=2, valid_o=1.
REQ-027 Stall: from pc_out=6, raise hazard for 3 edges -> pc_out=6 with instr_o/PC_o unchanged throughout, stall_cnt=3 (macro on) or 0 (macro off).
REQ-028 Flush priority: with hazard=1, branch_taken=1, branch_target=16'h0041 -> pc_out=16'h0040, instr_o=0, PC_o=0, valid_o=0, stall_cnt=0.
REQ-029 Wrap: flush to branch_target=16'hFFFE, then advance -> pc_out=0, PC_o=0, valid_o=1.
REQ-030 Async reset: drop reset between edges during a stall -> all outputs reach reset values before the next clk edge.
REQ-031 Saturation (macro on): hold hazard=1 for 300 edges -> stall_cnt=8'hFF; release hazard -> stall_cnt=0 after one edge.

Source files
------------

// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register with fetch program counter.
// Each rising clk edge takes exactly one action, highest priority first:
//   branch_taken -> redirect pc_out to the even-aligned branch_target and
//                   load a NOP bubble into the ID register
//   hazard       -> stall: hold pc_out and the whole ID register
//   otherwise    -> advance: pc_out += 2 and latch instr_in into the ID register
// Ports:
//   clk, reset (async, active-low)
//   hazard, branch_taken, branch_target[15:0], instr_in[15:0] : inputs
//   pc_out[15:0]    : fetch address to instruction memory
//   instr_o[15:0]   : registered instruction to ID
//   PC_o[15:0]      : registered PC+2 of instr_o
//   valid_o         : instr_o is a real instruction, not a bubble
//   stall_cnt[7:0]  : saturating consecutive-stall counter
// Optional feature: define IFID_STALL_CNT_EN to build the stall counter;
// when undefined stall_cnt is tied to zero and no counter exists.
module if_id_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        hazard,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic [15:0] instr_in,
  output logic [15:0] pc_out,
  output logic [15:0] instr_o,
  output logic [15:0] PC_o,
  output logic        valid_o,
  output logic [7:0]  stall_cnt
);

  localparam int unsigned XLEN  = 16;
  localparam int unsigned CNT_W = 8;

  logic [XLEN-1:0] pc_q,      pc_d;
  logic [XLEN-1:0] instr_q,   instr_d;
  logic [XLEN-1:0] pc_next_q, pc_next_d;
  logic            valid_q,   valid_d;
  logic [XLEN-1:0] pc_inc;

  // Truncated increment gives the 16'hFFFE -> 16'h0000 wrap for free.
  assign pc_inc = pc_q + XLEN'(2);

  // Next-state selection: flush beats stall beats advance.
  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    pc_next_d = pc_next_q;
    valid_d   = valid_q;
    if (branch_taken) begin
      // Clearing bit 0 keeps the fetch address halfword aligned.
      pc_d      = branch_target & ~XLEN'(1);
      instr_d   = '0;
      pc_next_d = '0;
      valid_d   = 1'b0;
    end else if (!hazard) begin
      pc_d      = pc_inc;
      instr_d   = instr_in;
      pc_next_d = pc_inc;
      valid_d   = 1'b1;
    end
  end

  // Pipeline and PC state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= '0;
      instr_q   <= '0;
      pc_next_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pc_next_q <= pc_next_d;
      valid_q   <= valid_d;
    end
  end

  assign pc_out  = pc_q;
  assign instr_o = instr_q;
  assign PC_o    = pc_next_q;
  assign valid_o = valid_q;

`ifdef IFID_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Counts consecutive stall edges, saturating; any non-stall edge clears it.
  always_comb begin
    stall_cnt_d = '0;
    if (hazard && !branch_taken) begin
      stall_cnt_d = (stall_cnt_q == {CNT_W{1'b1}}) ? stall_cnt_q
                                                   : stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed vector table, hand-written
// async-reset and saturation sequences, then randomized traffic against a
// behavioural model of the fetch/decode register.
module tb_if_id_stage;

  logic        clk;
  logic        reset;
  logic        hazard;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] instr_in;
  logic [15:0] pc_out;
  logic [15:0] instr_o;
  logic [15:0] PC_o;
  logic        valid_o;
  logic [7:0]  stall_cnt;

  int n_chk;
  int n_fail;
  int stall_en;

  // Behavioural model state (plain integers)
  int m_pc, m_instr, m_pco, m_valid, m_cnt;

  typedef struct {
    logic        hz;
    logic        br;
    logic [15:0] tgt;
    logic [15:0] ins;
    logic [15:0] e_pc;
    logic [15:0] e_instr;
    logic [15:0] e_pco;
    logic        e_valid;
    logic [7:0]  e_cnt;   // value with counter built in
  } vec_t;

  vec_t vecs[$];

  if_id_stage dut (
    .clk           (clk),
    .reset         (reset),
    .hazard        (hazard),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr_in      (instr_in),
    .pc_out        (pc_out),
    .instr_o       (instr_o),
    .PC_o          (PC_o),
    .valid_o       (valid_o),
    .stall_cnt     (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] pc, input logic [15:0] ins,
                         input logic [15:0] pco, input logic v, input logic [7:0] cnt);
    chk({tag, ".pc_out"},    32'(pc_out),    32'(pc));
    chk({tag, ".instr_o"},   32'(instr_o),   32'(ins));
    chk({tag, ".PC_o"},      32'(PC_o),      32'(pco));
    chk({tag, ".valid_o"},   32'(valid_o),   32'(v));
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(cnt));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic hz, input logic br, input logic [15:0] tgt,
                         input logic [15:0] ins, input logic [15:0] pc,
                         input logic [15:0] ei, input logic [15:0] pco,
                         input logic v, input logic [7:0] cnt);
    vec_t t;
    t.hz = hz; t.br = br; t.tgt = tgt; t.ins = ins;
    t.e_pc = pc; t.e_instr = ei; t.e_pco = pco; t.e_valid = v; t.e_cnt = cnt;
    vecs.push_back(t);
  endtask

  // Model: one edge of the IF/ID stage from the driven inputs.
  task automatic model_edge(input logic hz, input logic br, input logic [15:0] tgt,
                            input logic [15:0] ins);
    if (br) begin
      m_pc = int'(tgt) - (int'(tgt) % 2);
      m_instr = 0; m_pco = 0; m_valid = 0;
    end else if (!hz) begin
      m_pco = (m_pc + 2) % 65536;
      m_pc = m_pco;
      m_instr = int'(ins);
      m_valid = 1;
    end
    if (hz && !br) m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
    else m_cnt = 0;
  endtask

  task automatic model_reset();
    m_pc = 0; m_instr = 0; m_pco = 0; m_valid = 0; m_cnt = 0;
  endtask

  task automatic chk_model(input string tag);
    chk_all(tag, 16'(m_pc), 16'(m_instr), 16'(m_pco), m_valid[0], 8'(m_cnt * stall_en));
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
`ifdef IFID_STALL_CNT_EN
    stall_en = 1;
`else
    stall_en = 0;
`endif
    reset = 1'b0; hazard = 1'b0; branch_taken = 1'b0;
    branch_target = 16'h0000; instr_in = 16'h1234;

    // Directed table, applied right after reset release.
    add_vec(0, 0, 16'h0000, 16'h1234, 16'h0002, 16'h1234, 16'h0002, 1, 0);
    add_vec(0, 0, 16'h0000, 16'h1111, 16'h0004, 16'h1111, 16'h0004, 1, 0);
    add_vec(0, 0, 16'h0000, 16'h2222, 16'h0006, 16'h2222, 16'h0006, 1, 0);
    add_vec(1, 0, 16'h0000, 16'h3333, 16'h0006, 16'h2222, 16'h0006, 1, 1);
    add_vec(1, 0, 16'h0000, 16'h3333, 16'h0006, 16'h2222, 16'h0006, 1, 2);
    add_vec(1, 0, 16'h0000, 16'h3333, 16'h0006, 16'h2222, 16'h0006, 1, 3);
    add_vec(0, 0, 16'h0000, 16'h3333, 16'h0008, 16'h3333, 16'h0008, 1, 0);
    add_vec(1, 1, 16'h0041, 16'h4444, 16'h0040, 16'h0000, 16'h0000, 0, 0);
    add_vec(0, 1, 16'h1235, 16'h4444, 16'h1234, 16'h0000, 16'h0000, 0, 0);
    add_vec(1, 1, 16'hFFFE, 16'h4444, 16'hFFFE, 16'h0000, 16'h0000, 0, 0);
    add_vec(0, 0, 16'h0000, 16'h5555, 16'h0000, 16'h5555, 16'h0000, 1, 0);
    add_vec(1, 0, 16'h0000, 16'h6666, 16'h0000, 16'h5555, 16'h0000, 1, 1);
    add_vec(0, 0, 16'h0000, 16'h7777, 16'h0002, 16'h7777, 16'h0002, 1, 0);

    // Reset held for two cycles; outputs must sit at reset values.
    step();
    chk_all("reset0", 16'h0, 16'h0, 16'h0, 1'b0, 8'h0);
    step();
    chk_all("reset1", 16'h0, 16'h0, 16'h0, 1'b0, 8'h0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      hazard = vecs[i].hz;
      branch_taken = vecs[i].br;
      branch_target = vecs[i].tgt;
      instr_in = vecs[i].ins;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pco,
              vecs[i].e_valid, 8'(int'(vecs[i].e_cnt) * stall_en));
    end

    // Async reset dropped between edges during a stall.
    hazard = 1'b1; branch_taken = 1'b0; instr_in = 16'hABCD;
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    chk_all("async_rst", 16'h0, 16'h0, 16'h0, 1'b0, 8'h0);
    #2;
    reset = 1'b1;
    hazard = 1'b0; instr_in = 16'hBEEF;
    step();
    chk_all("post_rst", 16'h0002, 16'hBEEF, 16'h0002, 1'b1, 8'h0);

    // Saturation: 300 consecutive stall edges, then release.
    hazard = 1'b1; instr_in = 16'hCAFE;
    for (int k = 0; k < 300; k++) step();
    chk_all("sat", 16'h0002, 16'hBEEF, 16'h0002, 1'b1, 8'(255 * stall_en));
    hazard = 1'b0;
    step();
    chk_all("sat_rel", 16'h0004, 16'hCAFE, 16'h0004, 1'b1, 8'h0);

    // Randomized traffic against the behavioural model.
    model_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      hazard = ($urandom_range(0, 9) < 3);
      branch_taken = ($urandom_range(0, 15) == 0);
      branch_target = 16'($urandom);
      instr_in = 16'($urandom);
      if (k >= 1000 && k < 1300) begin
        hazard = 1'b1;
        branch_taken = 1'b0;
      end
      step();
      model_edge(hazard, branch_taken, branch_target, instr_in);
      chk_model($sformatf("rand%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
